// File: rtl/letc_pkg.sv
// Shared core types: data word, register index and register-file geometry.
package letc_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_idx_t;

  localparam int NUM_GPRS = 32;

  // True when an enabled access targets a real (non-x0) register at the same index.
  function automatic logic idx_hit(input logic en, input reg_idx_t a, input reg_idx_t b);
    return en && (a == b) && (a != '0);
  endfunction

endpackage

// File: rtl/core_reg_file_scoreboard.sv
// Per-register pending-write bits for RAW stall detection against long-latency producers.
module core_reg_file_scoreboard
  import letc_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_wr_live,
  input  reg_idx_t i_rd_idx,
  input  logic     i_rsv_en,
  input  reg_idx_t i_rsv_idx,
  input  logic     i_flush,
  input  reg_idx_t i_rs1_idx,
  input  reg_idx_t i_rs2_idx,
  output logic     o_rs1_pending,
  output logic     o_rs2_pending
);

  logic [NUM_GPRS-1:1] r_pending;
  logic [NUM_GPRS-1:1] w_pending_nxt;
  logic [NUM_GPRS-1:0] w_pending_all;
  logic                w_rs1_retire;
  logic                w_rs2_retire;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_flush) begin
      w_pending_nxt = '0;
    end else begin
      for (int i = 1; i < NUM_GPRS; i++) begin
        // A new reservation outranks the producer retiring into the same index.
        if (idx_hit(i_rsv_en, i_rsv_idx, reg_idx_t'(i))) begin
          w_pending_nxt[i] = 1'b1;
        end else if (idx_hit(i_wr_live, i_rd_idx, reg_idx_t'(i))) begin
          w_pending_nxt[i] = 1'b0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign w_pending_all = {r_pending, 1'b0};
  assign w_rs1_retire  = BYPASS_EN && idx_hit(i_wr_live, i_rd_idx, i_rs1_idx);
  assign w_rs2_retire  = BYPASS_EN && idx_hit(i_wr_live, i_rd_idx, i_rs2_idx);
  assign o_rs1_pending = w_pending_all[i_rs1_idx] & ~w_rs1_retire;
  assign o_rs2_pending = w_pending_all[i_rs2_idx] & ~w_rs2_retire;

endmodule

// File: rtl/core_reg_file.sv
// Integer register file: x1..x31 storage, one write port, two combinational read ports with bypass.
module core_reg_file
  import letc_pkg::*;
#(
  parameter bit BYPASS_EN  = 1'b1,
  parameter bit RESET_REGS = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     rd_we,
  input  reg_idx_t rd_idx,
  input  word_t    rd_wdata,
  input  reg_idx_t rs1_idx,
  output word_t    rs1_rdata,
  output logic     rs1_pending,
  input  reg_idx_t rs2_idx,
  output word_t    rs2_rdata,
  output logic     rs2_pending,
  input  logic     rsv_en,
  input  reg_idx_t rsv_idx,
  input  logic     flush,
  output logic     stall
);

  word_t r_regs [NUM_GPRS];
  logic  w_wr_live;
  logic  w_wr_commit;
  logic  w_rs1_byp;
  logic  w_rs2_byp;

  // A write presented while reset is held is discarded and never forwarded.
  assign w_wr_live   = rd_we & rst_n;
  assign w_wr_commit = w_wr_live && (rd_idx != '0);

  generate
    if (RESET_REGS) begin : g_regs_rst
      // NOTE: resetting the array costs a reset net per flop; the no-reset variant below avoids it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < NUM_GPRS; i++) begin
            r_regs[i] <= '0;
          end
        end else if (w_wr_commit) begin
          r_regs[rd_idx] <= rd_wdata;
        end
      end
    end else begin : g_regs_norst
      always_ff @(posedge clk) begin
        if (w_wr_commit) begin
          r_regs[rd_idx] <= rd_wdata;
        end
      end
    end
  endgenerate

  assign w_rs1_byp = BYPASS_EN && idx_hit(w_wr_live, rd_idx, rs1_idx);
  assign w_rs2_byp = BYPASS_EN && idx_hit(w_wr_live, rd_idx, rs2_idx);

  // x0 never touches the array: entry 0 is written only by reset and never read.
  assign rs1_rdata = (rs1_idx == '0) ? '0 : (w_rs1_byp ? rd_wdata : r_regs[rs1_idx]);
  assign rs2_rdata = (rs2_idx == '0) ? '0 : (w_rs2_byp ? rd_wdata : r_regs[rs2_idx]);

  core_reg_file_scoreboard #(
    .BYPASS_EN (BYPASS_EN)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_wr_live     (w_wr_live),
    .i_rd_idx      (rd_idx),
    .i_rsv_en      (rsv_en),
    .i_rsv_idx     (rsv_idx),
    .i_flush       (flush),
    .i_rs1_idx     (rs1_idx),
    .i_rs2_idx     (rs2_idx),
    .o_rs1_pending (rs1_pending),
    .o_rs2_pending (rs2_pending)
  );

  assign stall = rs1_pending | rs2_pending;

endmodule

// File: tb/tb_core_reg_file.sv
// Directed bench for core_reg_file: reference model checked every cycle plus literal spot checks.
module tb_core_reg_file;
  import letc_pkg::*;

  localparam bit BYPASS_EN  = 1'b1;
  localparam bit RESET_REGS = 1'b1;

  logic     clk = 1'b0;
  logic     rst_n;
  logic     rd_we;
  reg_idx_t rd_idx;
  word_t    rd_wdata;
  reg_idx_t rs1_idx;
  word_t    rs1_rdata;
  logic     rs1_pending;
  reg_idx_t rs2_idx;
  word_t    rs2_rdata;
  logic     rs2_pending;
  logic     rsv_en;
  reg_idx_t rsv_idx;
  logic     flush;
  logic     stall;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  word_t m_regs [NUM_GPRS];
  bit    m_pend [NUM_GPRS];

  core_reg_file #(
    .BYPASS_EN  (BYPASS_EN),
    .RESET_REGS (RESET_REGS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_we       (rd_we),
    .rd_idx      (rd_idx),
    .rd_wdata    (rd_wdata),
    .rs1_idx     (rs1_idx),
    .rs1_rdata   (rs1_rdata),
    .rs1_pending (rs1_pending),
    .rs2_idx     (rs2_idx),
    .rs2_rdata   (rs2_rdata),
    .rs2_pending (rs2_pending),
    .rsv_en      (rsv_en),
    .rsv_idx     (rsv_idx),
    .flush       (flush),
    .stall       (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state updated from the rules at each edge.
  initial begin
    for (int i = 0; i < NUM_GPRS; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_GPRS; i++) begin
        m_pend[i] = 1'b0;
        if (RESET_REGS) m_regs[i] = '0;
      end
    end else begin
      if (rd_we && rd_idx != 0) m_regs[rd_idx] = rd_wdata;
      if (flush) begin
        for (int i = 0; i < NUM_GPRS; i++) m_pend[i] = 1'b0;
      end else begin
        if (rd_we && rd_idx != 0) m_pend[rd_idx] = 1'b0;
        if (rsv_en && rsv_idx != 0) m_pend[rsv_idx] = 1'b1;
      end
    end
  end

  function automatic word_t exp_rdata(input reg_idx_t idx);
    if (idx == 0) return '0;
    if (BYPASS_EN && rst_n && rd_we && rd_idx == idx) return rd_wdata;
    return m_regs[idx];
  endfunction

  function automatic logic exp_pend(input reg_idx_t idx);
    if (idx == 0 || !rst_n) return 1'b0;
    if (BYPASS_EN && rd_we && rd_idx == idx) return 1'b0;
    return m_pend[idx];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_rs1_rdata", rs1_rdata, exp_rdata(rs1_idx));
      check("model_rs2_rdata", rs2_rdata, exp_rdata(rs2_idx));
      check("model_rs1_pending", 32'(rs1_pending), 32'(exp_pend(rs1_idx)));
      check("model_rs2_pending", 32'(rs2_pending), 32'(exp_pend(rs2_idx)));
      check("model_stall", 32'(stall), 32'(exp_pend(rs1_idx) | exp_pend(rs2_idx)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_we = 1'b0; rd_idx = '0; rd_wdata = '0;
    rsv_en = 1'b0; rsv_idx = '0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    rs1_idx = '0; rs2_idx = '0;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    rs1_idx = 5'd5; rs2_idx = 5'd31;
    #1;
    check("in_reset_rs1_rdata", rs1_rdata, 32'h0);
    check("in_reset_stall", 32'(stall), 32'h0);
    step();
    step();
    rst_n = 1'b1;

    // All 32 indices read as zero on both ports after reset.
    for (int i = 0; i < NUM_GPRS; i++) begin
      rs1_idx = reg_idx_t'(i); rs2_idx = reg_idx_t'(31 - i);
      @(negedge clk);
      check("reset_rs1_zero", rs1_rdata, 32'h0);
      check("reset_rs2_zero", rs2_rdata, 32'h0);
      check("reset_stall", 32'(stall), 32'h0);
      step();
    end

    // Write x5, read back on both ports.
    rd_we = 1'b1; rd_idx = 5'd5; rd_wdata = 32'hDEADBEEF; rs1_idx = '0; rs2_idx = '0;
    step();
    idle();
    rs1_idx = 5'd5; rs2_idx = 5'd5;
    @(negedge clk);
    check("x5_rs1", rs1_rdata, 32'hDEADBEEF);
    check("x5_rs2", rs2_rdata, 32'hDEADBEEF);
    step();

    // Writes to x0 are ignored, including same-cycle forwarding.
    rd_we = 1'b1; rd_idx = '0; rd_wdata = 32'hFFFFFFFF; rs1_idx = '0;
    @(negedge clk);
    check("x0_same_cycle", rs1_rdata, 32'h0);
    step();
    idle();
    @(negedge clk);
    check("x0_next_cycle", rs1_rdata, 32'h0);
    step();

    // Same-cycle bypass over a prior value of 1.
    rd_we = 1'b1; rd_idx = 5'd7; rd_wdata = 32'h1;
    step();
    rd_we = 1'b1; rd_idx = 5'd7; rd_wdata = 32'h12345678; rs2_idx = 5'd7;
    @(negedge clk);
    check("bypass_rs2", rs2_rdata, BYPASS_EN ? 32'h12345678 : 32'h1);
    step();
    idle();
    @(negedge clk);
    check("x7_after_write", rs2_rdata, 32'h12345678);
    step();

    // Reserve x10, observe stall, retire with a write.
    rsv_en = 1'b1; rsv_idx = 5'd10; rs1_idx = '0; rs2_idx = '0;
    step();
    idle();
    rs1_idx = 5'd10;
    @(negedge clk);
    check("x10_pending", 32'(rs1_pending), 32'h1);
    check("x10_stall", 32'(stall), 32'h1);
    step();
    rd_we = 1'b1; rd_idx = 5'd10; rd_wdata = 32'hA5;
    @(negedge clk);
    check("x10_retire_pending", 32'(rs1_pending), BYPASS_EN ? 32'h0 : 32'h1);
    check("x10_retire_rdata", rs1_rdata, BYPASS_EN ? 32'hA5 : 32'h0);
    step();
    idle();
    @(negedge clk);
    check("x10_cleared", 32'(rs1_pending), 32'h0);
    step();

    // Write and reserve x3 together, reserve x4, then flush with a competing reservation.
    rd_we = 1'b1; rd_idx = 5'd3; rd_wdata = 32'h33; rsv_en = 1'b1; rsv_idx = 5'd3; rs1_idx = '0;
    step();
    idle();
    rsv_en = 1'b1; rsv_idx = 5'd4; rs1_idx = 5'd3;
    @(negedge clk);
    check("x3_rsv_wins", 32'(rs1_pending), 32'h1);
    step();
    idle();
    rs1_idx = 5'd3; rs2_idx = 5'd4;
    @(negedge clk);
    check("x4_pending", 32'(rs2_pending), 32'h1);
    step();
    flush = 1'b1; rsv_en = 1'b1; rsv_idx = 5'd11; rd_we = 1'b1; rd_idx = 5'd12; rd_wdata = 32'hC;
    step();
    idle();
    @(negedge clk);
    check("flush_x3", 32'(rs1_pending), 32'h0);
    check("flush_x4", 32'(rs2_pending), 32'h0);
    step();
    rs1_idx = 5'd11; rs2_idx = 5'd12;
    @(negedge clk);
    check("flush_beats_rsv", 32'(rs1_pending), 32'h0);
    check("flush_write_commits", rs2_rdata, 32'hC);
    step();

    // Reset pulse with x9 pending: immediate clear, in-reset write discarded.
    rd_we = 1'b1; rd_idx = 5'd9; rd_wdata = 32'h99; rsv_en = 1'b1; rsv_idx = 5'd9; rs2_idx = '0;
    step();
    idle();
    rs1_idx = 5'd9;
    @(negedge clk);
    check("x9_pending", 32'(rs1_pending), 32'h1);
    check("x9_value", rs1_rdata, 32'h99);
    step();
    rst_n = 1'b0; rd_we = 1'b1; rd_idx = 5'd9; rd_wdata = 32'h77;
    #1;
    check("async_pending_clear", 32'(rs1_pending), 32'h0);
    check("async_stall_clear", 32'(stall), 32'h0);
    check("async_x9_zero", rs1_rdata, 32'h0);
    step();
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    check("x9_after_reset", rs1_rdata, 32'h0);
    check("x9_pending_after_reset", 32'(rs1_pending), 32'h0);
    step();
    step();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/core_reg_file.md
Name: core_reg_file

Overview:
- Integer register file at the far end of the write-back path. It consumes the word produced by the write-back source mux and serves operands to decode/issue.
- Provides 31 architectural registers (x1..x31); x0 is hardwired to zero.
- Provides one write port, two combinational read ports with optional write-through bypass, and a per-register pending-write scoreboard. Issue uses the scoreboard to stall on RAW hazards against long-latency (load/CSR) results.

Parameters:
- BYPASS_EN, 1, when 1 a same-cycle write to the read index is forwarded to the read data; when 0 the read returns the pre-write value.
- RESET_REGS, 1, when 1 x1..x31 clear to 0 on reset; when 0 the array has no reset (pending bits are always reset).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- rd_we  in  1  write enable from write-back
- rd_idx  in  5  destination register index
- rd_wdata  in  32 (word_t)  write data (output of the write-back source mux)
- rs1_idx  in  5  read port 1 index
- rs1_rdata  out  32 (word_t)  read port 1 data
- rs1_pending  out  1  rs1_idx has an outstanding reserved write
- rs2_idx  in  5  read port 2 index
- rs2_rdata  out  32 (word_t)  read port 2 data
- rs2_pending  out  1  rs2_idx has an outstanding reserved write
- rsv_en  in  1  issue reserves rsv_idx as pending (long-latency producer issued)
- rsv_idx  in  5  register index to reserve
- flush  in  1  clear all pending bits (pipeline squash)
- stall  out  1  rs1_pending | rs2_pending

Behaviour:
- Reset (rst_n low, asynchronous): pending[31:1] = 0. If RESET_REGS = 1, regs[31:1] = 0.
  - While in reset, read outputs reflect the array contents (0 when RESET_REGS = 1), and rs*_pending = 0 and stall = 0.
  - Reset asserted mid-operation discards any write in that cycle and clears every reservation.
- Write: on the rising clk edge with rd_we = 1 and rd_idx != 0, regs[rd_idx] <= rd_wdata. Writes to x0 are ignored.
- Read: combinational, zero latency.
  - rsN_idx = 0 → rsN_rdata = 0 and rsN_pending = 0, always.
  - BYPASS_EN = 1 with rd_we = 1 and rd_idx == rsN_idx != 0 → rsN_rdata = rd_wdata in the same cycle.
  - Otherwise rsN_rdata = regs[rsN_idx].
  - Both ports may read the same index; both must return identical data.
- Scoreboard: one pending bit per register, 1..31.
  - Set on clk edge when rsv_en = 1 and rsv_idx != 0.
  - Cleared on clk edge when rd_we = 1 and rd_idx matches.
  - Same index written and reserved in one cycle → bit is 1 (the new reservation wins over the retiring producer).
  - flush = 1 → all bits 0 next cycle, overriding rsv_en in the same cycle. Writes still commit to the array during flush.
  - Reserving an already-pending index keeps it 1. This is legal: a WAW, single in-flight producer per index is guaranteed by issue.
- Pending outputs: rsN_pending = pending[rsN_idx] & ~(BYPASS_EN & rd_we & rd_idx == rsN_idx). With bypass, a retiring write resolves the hazard in the same cycle.
- stall is purely combinational from the rs*_pending outputs.
- No X propagation: indices are 5 bits, so every index is valid.

Decomposition:
- letc_pkg: word_t (existing); add reg_idx_t (logic [4:0]) and localparam NUM_GPRS = 32.
- Natural sub-module: core_reg_file_scoreboard. It holds the pending bits, the reserve/release/flush logic and the pending lookups. The array and bypass stay in core_reg_file.

Test Plan:
- Reset, then read all 32 indices on both ports → every rdata = 0x00000000 and stall = 0.
- Write x5 = 0xDEADBEEF, next cycle rs1_idx = 5 and rs2_idx = 5 → both rdata = 0xDEADBEEF.
- Write x0 = 0xFFFFFFFF with rs1_idx = 0 in the same cycle and the next → rs1_rdata = 0 in both cycles.
- Same-cycle bypass: rd_we = 1, rd_idx = 7, wdata = 0x12345678, rs2_idx = 7, prior x7 = 0x1 → rs2_rdata = 0x12345678 (BYPASS_EN = 1) or 0x1 (BYPASS_EN = 0).
- Scoreboard: rsv x10 → next cycle rs1_idx = 10 gives rs1_pending = 1 and stall = 1. Write x10 = 0xA5 → same cycle pending = 0 (bypass on), and the bit is clear afterwards.
- Simultaneous write + reserve of x3, then flush while x3 and x4 are pending; also rst_n pulsed low mid-sequence with x9 pending → x3 stays pending after the first edge; all pending = 0 after flush. After the reset pulse, pending = 0 immediately (asynchronous) and x9 reads 0.
